// File: rtl/rvj1_dec_buf.sv
`default_nettype none
// ============================================================================
// Module   : rvj1_dec_buf
// Purpose  : RV32 subset decoder feeding a DEPTH-entry decoded-op queue.
//            Optional macro RVJ1_DEC_ILLEGAL_EN reports illegal encodings.
// Revision : 1.0 - initial release
// ============================================================================

package rvj1_dec_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        LSU_NO_CMD = 4'd0,
        LSU_LB     = 4'd1,
        LSU_LH     = 4'd2,
        LSU_LW     = 4'd3,
        LSU_LBU    = 4'd4,
        LSU_LHU    = 4'd5,
        LSU_SB     = 4'd6,
        LSU_SH     = 4'd7,
        LSU_SW     = 4'd8
    } lsu_ctrl_e;
endpackage

module rvj1_dec_buf
    import rvj1_dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RALEN = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  ifu_instr_i,
    input  logic [XLEN-1:0]  ifu_pc_i,
    input  logic             ifu_valid_i,
    output logic             ifu_ready_o,
    input  logic             flush_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [RALEN-1:0] rf_addr_a_o,
    output logic [RALEN-1:0] rf_addr_b_o,
    output logic [RALEN-1:0] alu_regdest_o,
    output logic [RALEN-1:0] lsu_regdest_o,
    output alu_op_e          alu_sel_o,
    output logic             rpa_or_pc_o,
    output logic             rpb_or_imm_o,
    output logic             alu_write_rf_o,
    output logic             lsu_ctrl_valid_o,
    output lsu_ctrl_e        lsu_ctrl_o,
    output logic [XLEN-1:0]  immediate_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             illegal_o
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [6:0]         c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]         c_OPC_OP    = 7'b0110011;
    localparam logic [6:0]         c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0]         c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0]         c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]         c_OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [RALEN-1:0] rf_addr_a;
        logic [RALEN-1:0] rf_addr_b;
        logic [RALEN-1:0] alu_regdest;
        logic [RALEN-1:0] lsu_regdest;
        alu_op_e          alu_sel;
        logic             rpa_or_pc;
        logic             rpb_or_imm;
        logic             alu_write_rf;
        logic             lsu_ctrl_valid;
        lsu_ctrl_e        lsu_ctrl;
        logic [XLEN-1:0]  immediate;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } entry_t;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [RALEN-1:0] w_rd;
    logic [RALEN-1:0] w_rs1;
    logic [RALEN-1:0] w_rs2;
    logic [XLEN-1:0]  w_imm_i;
    logic [XLEN-1:0]  w_imm_s;
    logic [XLEN-1:0]  w_imm_u;
    logic [XLEN-1:0]  w_imm_sh;
    logic             w_bad;
    entry_t           w_dec;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    entry_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    assign w_opcode = ifu_instr_i[6:0];
    assign w_funct3 = ifu_instr_i[14:12];
    assign w_funct7 = ifu_instr_i[31:25];
    assign w_rd     = RALEN'(ifu_instr_i[11:7]);
    assign w_rs1    = RALEN'(ifu_instr_i[19:15]);
    assign w_rs2    = RALEN'(ifu_instr_i[24:20]);
    assign w_imm_i  = XLEN'($signed(ifu_instr_i[31:20]));
    assign w_imm_s  = XLEN'($signed({ifu_instr_i[31:25], ifu_instr_i[11:7]}));
    assign w_imm_u  = XLEN'($signed({ifu_instr_i[31:12], 12'b0}));
    assign w_imm_sh = XLEN'(ifu_instr_i[24:20]);

    // funct3 -> base ALU op shared by OP and OPIMM; funct7 variants patched by caller
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

    always_comb begin
        w_dec = '0;
        w_bad = 1'b0;
        case (w_opcode)
            c_OPC_OPIMM: begin
                w_dec.rf_addr_a    = w_rs1;
                w_dec.rpb_or_imm   = 1'b1;
                w_dec.alu_regdest  = w_rd;
                w_dec.alu_write_rf = 1'b1;
                w_dec.alu_sel      = f3_to_alu(w_funct3);
                w_dec.immediate    = w_imm_i;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_dec.immediate = w_imm_sh;
                    if (w_funct3 == 3'b101 && w_funct7 == 7'h20) begin
                        w_dec.alu_sel = ALU_OP_SRA;
                    end else if (w_funct7 != 7'h00) begin
                        w_bad = 1'b1;
                    end
                end
            end
            c_OPC_OP: begin
                w_dec.rf_addr_a    = w_rs1;
                w_dec.rf_addr_b    = w_rs2;
                w_dec.alu_regdest  = w_rd;
                w_dec.alu_write_rf = 1'b1;
                w_dec.alu_sel      = f3_to_alu(w_funct3);
                if (w_funct7 == 7'h20 && w_funct3 == 3'b000) begin
                    w_dec.alu_sel = ALU_OP_SUB;
                end else if (w_funct7 == 7'h20 && w_funct3 == 3'b101) begin
                    w_dec.alu_sel = ALU_OP_SRA;
                end else if (w_funct7 != 7'h00) begin
                    w_bad = 1'b1;
                end
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec.rpa_or_pc    = (w_opcode == c_OPC_AUIPC);
                w_dec.rpb_or_imm   = 1'b1;
                w_dec.alu_regdest  = w_rd;
                w_dec.alu_write_rf = 1'b1;
                w_dec.immediate    = w_imm_u;
            end
            c_OPC_LOAD: begin
                w_dec.rf_addr_a      = w_rs1;
                w_dec.rpb_or_imm     = 1'b1;
                w_dec.immediate      = w_imm_i;
                w_dec.lsu_ctrl_valid = 1'b1;
                w_dec.lsu_regdest    = w_rd;
                case (w_funct3)
                    3'b000:  w_dec.lsu_ctrl = LSU_LB;
                    3'b001:  w_dec.lsu_ctrl = LSU_LH;
                    3'b010:  w_dec.lsu_ctrl = LSU_LW;
                    3'b100:  w_dec.lsu_ctrl = LSU_LBU;
                    3'b101:  w_dec.lsu_ctrl = LSU_LHU;
                    default: w_bad = 1'b1;
                endcase
            end
            c_OPC_STORE: begin
                w_dec.rf_addr_a      = w_rs1;
                w_dec.rf_addr_b      = w_rs2;
                w_dec.rpb_or_imm     = 1'b1;
                w_dec.immediate      = w_imm_s;
                w_dec.lsu_ctrl_valid = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.lsu_ctrl = LSU_SB;
                    3'b001:  w_dec.lsu_ctrl = LSU_SH;
                    3'b010:  w_dec.lsu_ctrl = LSU_SW;
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
        // Any unsupported encoding degrades to a NOP that still carries its PC
        if (w_bad) begin
            w_dec = '0;
        end
`ifdef RVJ1_DEC_ILLEGAL_EN
        w_dec.illegal = w_bad;
`endif
        w_dec.pc = ifu_pc_i;
    end

    assign ifu_ready_o = (r_count != c_DEPTH);
    assign dec_valid_o = (r_count != '0);
    assign w_push      = ifu_valid_i && ifu_ready_o && !flush_i;
    assign w_pop       = dec_valid_o && dec_ready_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    assign w_head = dec_valid_o ? r_mem[r_rd_ptr] : '0;

    assign rf_addr_a_o      = w_head.rf_addr_a;
    assign rf_addr_b_o      = w_head.rf_addr_b;
    assign alu_regdest_o    = w_head.alu_regdest;
    assign lsu_regdest_o    = w_head.lsu_regdest;
    assign alu_sel_o        = w_head.alu_sel;
    assign rpa_or_pc_o      = w_head.rpa_or_pc;
    assign rpb_or_imm_o     = w_head.rpb_or_imm;
    assign alu_write_rf_o   = w_head.alu_write_rf;
    assign lsu_ctrl_valid_o = w_head.lsu_ctrl_valid;
    assign lsu_ctrl_o       = w_head.lsu_ctrl;
    assign immediate_o      = w_head.immediate;
    assign pc_o             = w_head.pc;
    assign illegal_o        = w_head.illegal;

endmodule

`default_nettype wire
